// File: rtl/ccd_cds_sampler.sv
// ccd_cds_sampler: digital correlated double sampling on the receive side of
// the CCD phase generator. For each pixel it captures a reset level after
// phi_r falls and a signal level after phi_l2 rises. It pushes
// pixel = reset - signal (floored at 0) with its column index and a
// start-of-line tag into a 2-entry output FIFO.
// Optional feature: define CCD_TIMEOUT_EN to build the wait-state watchdog.
// Without it, timeout_err is constant 0.
//
// Stream handshake: pix_valid is high while the FIFO holds a pixel. A beat
// transfers on every clk edge where pix_valid && pix_ready. pix_data,
// pix_col and pix_sol stay unchanged while pix_valid && !pix_ready.
module ccd_cds_sampler #(
    parameter int ADC_W   = 12,
    parameter int COL_W   = 10,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phi_p,
    input  logic             phi_r,
    input  logic             phi_l2,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             clr_flags,
    output logic [ADC_W-1:0] pix_data,
    output logic [COL_W-1:0] pix_col,
    output logic             pix_sol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             ovf,
    output logic             timeout_err,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RST = 3'd1,
        S_SET_R    = 3'd2,
        S_WAIT_SIG = 3'd3,
        S_SET_S    = 3'd4,
        S_EMIT     = 3'd5
    } state_t;

    localparam int          ENTRY_W  = ADC_W + COL_W + 1;
    localparam logic [3:0]  SETTLE_V = 4'(SETTLE);

    state_t             state;
    logic [3:0]         settle_cnt;
    logic [ADC_W-1:0]   rst_lvl;
    logic [ADC_W-1:0]   sig_lvl;
    logic [COL_W-1:0]   col;
    logic               sol_pending;

    // {phi_p, phi_r, phi_l2}: first register stage and its one-cycle history
    logic [2:0]         phi_q;
    logic [2:0]         phi_d;
    logic               p_rise;
    logic               r_fall;
    logic               l2_rise;
    logic               wd_fire;

    logic [ENTRY_W-1:0] fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_cnt;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic [ADC_W-1:0]   pix_calc;
    logic [ENTRY_W-1:0] head;

    // Register the phases once, then keep the previous sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi_q <= '0;
            phi_d <= '0;
        end else begin
            phi_q <= {phi_p, phi_r, phi_l2};
            phi_d <= phi_q;
        end
    end

    assign p_rise  =  phi_q[2] & ~phi_d[2];
    assign r_fall  = ~phi_q[1] &  phi_d[1];
    assign l2_rise =  phi_q[0] & ~phi_d[0];

`ifdef CCD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wait_hold;

    // Cycles spent in a wait state with no edge that would leave or re-enter it
    assign wait_hold = ((state == S_WAIT_RST) & ~p_rise & ~r_fall) |
                       ((state == S_WAIT_SIG) & ~p_rise & ~r_fall & ~l2_rise);
    assign wd_fire   = wait_hold & (wd_cnt == WD_W'(TIMEOUT - 1));

    // Watchdog counts while waiting and restarts on every state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (wait_hold && !wd_fire)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    // Sticky watchdog flag; a new timeout beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout_err <= 1'b0;
        else if (wd_fire)
            timeout_err <= 1'b1;
        else if (clr_flags)
            timeout_err <= 1'b0;
    end
`else
    assign wd_fire     = 1'b0;
    // Constant 0: TIMEOUT only takes effect when the watchdog is built
    assign timeout_err = (TIMEOUT < 0);
`endif

    // Pixel sequencing: reset level, signal level, emit; phi_p rise restarts the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            rst_lvl     <= '0;
            sig_lvl     <= '0;
            col         <= '0;
            sol_pending <= 1'b0;
        end else if (p_rise) begin
            state       <= S_WAIT_RST;
            col         <= '0;
            sol_pending <= 1'b1;
        end else begin
            case (state)
                S_IDLE: ;
                S_WAIT_RST: begin
                    if (r_fall) begin
                        state      <= S_SET_R;
                        settle_cnt <= SETTLE_V;
                    end else if (wd_fire) begin
                        state <= S_IDLE;
                    end
                end
                S_SET_R: begin
                    if (settle_cnt == 4'd0) begin
                        rst_lvl <= adc_data;
                        state   <= S_WAIT_SIG;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_WAIT_SIG: begin
                    if (r_fall) begin
                        state      <= S_SET_R;
                        settle_cnt <= SETTLE_V;
                    end else if (l2_rise) begin
                        state      <= S_SET_S;
                        settle_cnt <= SETTLE_V;
                    end else if (wd_fire) begin
                        state <= S_IDLE;
                    end
                end
                S_SET_S: begin
                    if (settle_cnt == 4'd0) begin
                        sig_lvl <= adc_data;
                        state   <= S_EMIT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_EMIT: begin
                    col         <= col + 1'b1;
                    sol_pending <= 1'b0;
                    state       <= S_WAIT_RST;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fsm_state = state;
    assign pix_calc  = (sig_lvl > rst_lvl) ? '0 : (rst_lvl - sig_lvl);

    // A same-cycle phi_p rise aborts the pixel in EMIT as well
    assign push      = (state == S_EMIT) & ~p_rise;
    assign fifo_full = (fifo_cnt == 2'd2);
    assign pop       = pix_valid & pix_ready;
    assign push_ok   = push & (~fifo_full | pop);

    // Two-entry output FIFO; when full, a push is accepted only alongside a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {pix_calc, col, sol_pending};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky overflow flag; a dropped pixel beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (push && fifo_full && !pop)
            ovf <= 1'b1;
        else if (clr_flags)
            ovf <= 1'b0;
    end

    assign head      = fifo_mem[rd_ptr];
    assign pix_data  = head[ENTRY_W-1 -: ADC_W];
    assign pix_col   = head[COL_W:1];
    assign pix_sol   = head[0];
    assign pix_valid = (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// tb_ccd_cds_sampler: directed bench for ccd_cds_sampler (SETTLE=2, TIMEOUT=64).
// Expected pixels are queued by hand and matched against every accepted beat.
module tb_ccd_cds_sampler;

    localparam int ADC_W = 12;
    localparam int COL_W = 10;
    localparam int EW    = ADC_W + COL_W + 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_RST = 3'd1;
    localparam logic [2:0] ST_SET_S    = 3'd4;

    logic             clk;
    logic             rst_n;
    logic             phi_p;
    logic             phi_r;
    logic             phi_l2;
    logic [ADC_W-1:0] adc_data;
    logic             clr_flags;
    logic [ADC_W-1:0] pix_data;
    logic [COL_W-1:0] pix_col;
    logic             pix_sol;
    logic             pix_valid;
    logic             pix_ready;
    logic             ovf;
    logic             timeout_err;
    logic [2:0]       fsm_state;

    logic [EW-1:0]    exp_q[$];
    int               checks;
    int               failures;
    int               beats;
    int               beats_mark;

    ccd_cds_sampler #(
        .ADC_W(ADC_W), .COL_W(COL_W), .SETTLE(2), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phi_p(phi_p), .phi_r(phi_r), .phi_l2(phi_l2),
        .adc_data(adc_data), .clr_flags(clr_flags),
        .pix_data(pix_data), .pix_col(pix_col), .pix_sol(pix_sol),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .ovf(ovf), .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [EW-1:0] mk(input logic [ADC_W-1:0] d,
                                         input logic [COL_W-1:0] c,
                                         input logic s);
        return {d, c, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sample at negedge, match each accepted beat to the queue head
    task automatic monitor_sample();
        logic [EW-1:0] e;
        if (rst_n && pix_valid && pix_ready) begin
            beats++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL pix_unexpected observed=0x%0h expected=none",
                       {pix_data, pix_col, pix_sol});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pix_beat", 32'({pix_data, pix_col, pix_sol}), 32'(e));
            end
        end
    endtask

    // Advance n cycles; leaves time at posedge+1 for driving and checking
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            monitor_sample();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_line();
        phi_p = 1'b1;
        tick(2);
        phi_p = 1'b0;
        tick(2);
    endtask

    task automatic do_pixel(input logic [ADC_W-1:0] rl, input logic [ADC_W-1:0] sl);
        adc_data = rl;
        phi_r    = 1'b1;
        tick(2);
        phi_r    = 1'b0;
        tick(8);
        adc_data = sl;
        phi_l2   = 1'b1;
        tick(8);
        phi_l2   = 1'b0;
        adc_data = 12'(ADC_W'($urandom_range(0, 4095)));
        tick(2);
    endtask

    initial begin
        checks = 0; failures = 0; beats = 0;
        rst_n = 1'b0; phi_p = 1'b0; phi_r = 1'b0; phi_l2 = 1'b0;
        adc_data = '0; clr_flags = 1'b0; pix_ready = 1'b1;
        tick(3);

        // Reset state
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_data", 32'(pix_data), 0);
        chk("rst_col", 32'(pix_col), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick(2);

        // Nominal pixels
        start_line();
        chk("line_state", 32'(fsm_state), 32'(ST_WAIT_RST));
        exp_q.push_back(mk(12'h500, 10'd0, 1'b1));
        do_pixel(12'h800, 12'h300);
        chk("nominal_beats", 32'(beats), 1);
        exp_q.push_back(mk(12'h801, 10'd1, 1'b0));
        do_pixel(12'hA00, 12'h1FF);

        // Saturation and equal levels
        exp_q.push_back(mk(12'h000, 10'd2, 1'b0));
        do_pixel(12'h100, 12'h180);
        exp_q.push_back(mk(12'h000, 10'd3, 1'b0));
        do_pixel(12'h400, 12'h400);
        chk("sat_beats", 32'(beats), 4);

        // Backpressure: third pixel dropped
        pix_ready = 1'b0;
        start_line();
        exp_q.push_back(mk(12'h0E0, 10'd0, 1'b1));
        do_pixel(12'h0F0, 12'h010);
        chk("bp_valid", 32'(pix_valid), 1);
        chk("bp_head_data", 32'(pix_data), 32'h0E0);
        chk("bp_head_sol", 32'(pix_sol), 1);
        exp_q.push_back(mk(12'hFFF, 10'd1, 1'b0));
        do_pixel(12'hFFF, 12'h000);
        chk("bp_ovf_before", 32'(ovf), 0);
        do_pixel(12'h555, 12'h111);
        chk("bp_ovf", 32'(ovf), 1);
        chk("bp_hold_data", 32'(pix_data), 32'h0E0);
        chk("bp_hold_col", 32'(pix_col), 0);
        beats_mark = beats;
        pix_ready = 1'b1;
        tick(4);
        chk("bp_drain_count", 32'(beats - beats_mark), 2);
        chk("bp_empty", 32'(pix_valid), 0);
        chk("bp_ovf_sticky", 32'(ovf), 1);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        chk("bp_ovf_clr", 32'(ovf), 0);

        // Line abort while in SET_S
        start_line();
        beats_mark = beats;
        adc_data = 12'h900;
        phi_r = 1'b1;
        tick(2);
        phi_r = 1'b0;
        tick(8);
        adc_data = 12'h100;
        phi_l2 = 1'b1;
        tick(2);
        chk("abort_in_set_s", 32'(fsm_state), 32'(ST_SET_S));
        phi_p = 1'b1;
        tick(2);
        phi_p = 1'b0;
        phi_l2 = 1'b0;
        tick(8);
        chk("abort_state", 32'(fsm_state), 32'(ST_WAIT_RST));
        chk("abort_no_push", 32'(beats - beats_mark), 0);
        exp_q.push_back(mk(12'h800, 10'd0, 1'b1));
        do_pixel(12'h900, 12'h100);

        // Async reset with two held pixels
        pix_ready = 1'b0;
        start_line();
        do_pixel(12'h300, 12'h100);
        do_pixel(12'h700, 12'h100);
        chk("pre_rst_valid", 32'(pix_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(pix_valid), 0);
        chk("arst_data", 32'(pix_data), 0);
        chk("arst_col", 32'(pix_col), 0);
        chk("arst_sol", 32'(pix_sol), 0);
        chk("arst_ovf", 32'(ovf), 0);
        chk("arst_state", 32'(fsm_state), 32'(ST_IDLE));
        tick(2);
        rst_n = 1'b1;
        pix_ready = 1'b1;
        tick(2);
        beats_mark = beats;
        do_pixel(12'h800, 12'h200);
        do_pixel(12'h600, 12'h100);
        chk("no_line_beats", 32'(beats - beats_mark), 0);
        chk("no_line_state", 32'(fsm_state), 32'(ST_IDLE));
        chk("no_line_valid", 32'(pix_valid), 0);

        // Watchdog: phi_p then no phi_r
        beats_mark = beats;
        start_line();
        tick(100);
        chk("wd_no_pixel", 32'(beats - beats_mark), 0);
`ifdef CCD_TIMEOUT_EN
        chk("wd_flag", 32'(timeout_err), 1);
        chk("wd_state", 32'(fsm_state), 32'(ST_IDLE));
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        chk("wd_flag_clr", 32'(timeout_err), 0);
`else
        chk("wd_flag", 32'(timeout_err), 0);
        chk("wd_state", 32'(fsm_state), 32'(ST_WAIT_RST));
`endif

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
